// File: rtl/dynamixel_status_receiver.sv
// dynamixel_status_receiver
//   Receives Dynamixel Protocol 2.0 status packets from the half-duplex servo
//   bus. The block contains an 8N1 UART receiver, a header/field parser with
//   byte-destuffing, and a CRC-16 (poly 0x8005) checker. Fields are assembled
//   in shadow registers and published only when the CRC matches.
//
// Ports
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   rx             bus receive data, idle high
//   packet_valid   1-cycle pulse, packet with good CRC completed
//   id             servo ID of the last valid packet
//   error          ERR byte of the last valid packet
//   value          destuffed param bytes 0..3, little-endian, missing bytes zero
//   param_count    destuffed param byte count, saturating at 255
//   crc_error      1-cycle pulse, packet completed with a CRC mismatch
//   framing_error  1-cycle pulse, stop bit sampled low
//
// UART states
//   state   | meaning
//   U_IDLE  | line idle, waiting for a falling edge
//   U_START | counting to the middle of the start bit to re-check it
//   U_DATA  | sampling 8 data bits, LSB first
//   U_STOP  | sampling the stop bit
//
// Parser states
//   state   | meaning
//   P_HDR1  | waiting for first header byte FF
//   P_HDR2  | expecting FF
//   P_HDR3  | expecting FD (extra FF keeps us here)
//   P_RSV   | expecting reserved byte 00
//   P_ID    | servo ID
//   P_LEN_L | length, low byte
//   P_LEN_H | length, high byte; range check
//   P_INST  | expecting status instruction 55
//   P_ERR   | error byte
//   P_PARAM | LEN-4 raw parameter bytes, destuffed
//   P_CRC_L | received CRC, low byte
//   P_CRC_H | received CRC, high byte; compare and publish
module dynamixel_status_receiver #(
    parameter int clocks_per_bit = 3,
    parameter int max_len        = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx,
    output logic        packet_valid,
    output logic [7:0]  id,
    output logic [7:0]  error,
    output logic [31:0] value,
    output logic [7:0]  param_count,
    output logic        crc_error,
    output logic        framing_error
);

    // Bit timer is a down-counter; clocks_per_bit must be at least 2.
    localparam int TW = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
    localparam logic [TW-1:0] TMR_BIT  = TW'(clocks_per_bit - 1);
    localparam logic [TW-1:0] TMR_HALF =
        TW'((clocks_per_bit / 2 > 0) ? (clocks_per_bit / 2 - 1) : 0);
    localparam logic [15:0] MAX_LEN = 16'(max_len);

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    typedef enum logic [3:0] {
        P_HDR1,
        P_HDR2,
        P_HDR3,
        P_RSV,
        P_ID,
        P_LEN_L,
        P_LEN_H,
        P_INST,
        P_ERR,
        P_PARAM,
        P_CRC_L,
        P_CRC_H
    } parser_state_t;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    uart_state_t   uart_state_q, uart_state_d;
    parser_state_t p_state_q, p_state_d;

    // UART datapath
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_stb_q, byte_stb_d;
    logic [7:0]    byte_q, byte_d;
    logic          frame_err_q, frame_err_d;

    // Parser datapath
    logic [15:0] len_q, len_d;
    logic [15:0] rem_q, rem_d;
    logic [7:0]  id_sh_q, id_sh_d;
    logic [7:0]  err_sh_q, err_sh_d;
    logic [31:0] val_sh_q, val_sh_d;
    logic [7:0]  cnt_sh_q, cnt_sh_d;
    logic [23:0] hist_q, hist_d;
    logic [1:0]  raw_cnt_q, raw_cnt_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_l_q, crc_l_d;

    // Outputs
    logic        packet_valid_q, packet_valid_d;
    logic        crc_error_q, crc_error_d;
    logic [7:0]  id_q, id_d;
    logic [7:0]  error_q, error_d;
    logic [31:0] value_q, value_d;
    logic [7:0]  param_count_q, param_count_d;

    logic [15:0] crc_next;
    logic [15:0] len_full;
    logic        len_bad;
    logic        is_stuff;

    assign crc_next = crc16_byte(crc_q, byte_q);
    assign len_full = {byte_q, len_q[7:0]};
    assign len_bad  = (len_full < 16'd4) || (len_full > MAX_LEN);
    // Stuffing is decided on raw history only, so the first three param
    // bytes can never qualify.
    assign is_stuff = (raw_cnt_q == 2'd3) && (hist_q == 24'hFF_FF_FD);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uart_state_q <= U_IDLE;
            p_state_q    <= P_HDR1;
        end else begin
            uart_state_q <= uart_state_d;
            p_state_q    <= p_state_d;
        end
    end

    // ------------------------------------------------------------------
    // UART next state
    // ------------------------------------------------------------------
    always_comb begin
        uart_state_d = uart_state_q;
        case (uart_state_q)
            U_IDLE:  if (rx_prev_q && !rx_sync_q) uart_state_d = U_START;
            U_START: if (tmr_q == '0) uart_state_d = rx_sync_q ? U_IDLE : U_DATA;
            U_DATA:  if (tmr_q == '0 && bit_cnt_q == 3'd7) uart_state_d = U_STOP;
            U_STOP:  if (tmr_q == '0) uart_state_d = U_IDLE;
            default: uart_state_d = U_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // UART datapath
    // ------------------------------------------------------------------
    always_comb begin
        tmr_d       = tmr_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_stb_d  = 1'b0;
        byte_d      = byte_q;
        frame_err_d = 1'b0;
        case (uart_state_q)
            U_IDLE: begin
                tmr_d     = TMR_HALF;
                bit_cnt_d = 3'd0;
            end
            U_START: begin
                tmr_d = (tmr_q == '0) ? TMR_BIT : tmr_q - TW'(1);
            end
            U_DATA: begin
                if (tmr_q == '0) begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    tmr_d     = TMR_BIT;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            U_STOP: begin
                if (tmr_q == '0) begin
                    if (rx_sync_q) begin
                        byte_stb_d = 1'b1;
                        byte_d     = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: tmr_d = TMR_HALF;
        endcase
    end

    // ------------------------------------------------------------------
    // Parser next state
    // ------------------------------------------------------------------
    always_comb begin
        p_state_d = p_state_q;
        if (frame_err_q) begin
            p_state_d = P_HDR1;
        end else if (byte_stb_q) begin
            case (p_state_q)
                P_HDR1:  if (byte_q == 8'hFF) p_state_d = P_HDR2;
                P_HDR2:  p_state_d = (byte_q == 8'hFF) ? P_HDR3 : P_HDR1;
                P_HDR3: begin
                    if (byte_q == 8'hFD)      p_state_d = P_RSV;
                    else if (byte_q != 8'hFF) p_state_d = P_HDR1;
                end
                P_RSV:   p_state_d = (byte_q == 8'h00) ? P_ID : P_HDR1;
                P_ID:    p_state_d = P_LEN_L;
                P_LEN_L: p_state_d = P_LEN_H;
                P_LEN_H: p_state_d = len_bad ? P_HDR1 : P_INST;
                P_INST:  p_state_d = (byte_q == 8'h55) ? P_ERR : P_HDR1;
                P_ERR:   p_state_d = (len_q == 16'd4) ? P_CRC_L : P_PARAM;
                P_PARAM: if (rem_q == 16'd1) p_state_d = P_CRC_L;
                P_CRC_L: p_state_d = P_CRC_H;
                P_CRC_H: p_state_d = P_HDR1;
                default: p_state_d = P_HDR1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Parser datapath and outputs
    // ------------------------------------------------------------------
    always_comb begin
        len_d          = len_q;
        rem_d          = rem_q;
        id_sh_d        = id_sh_q;
        err_sh_d       = err_sh_q;
        val_sh_d       = val_sh_q;
        cnt_sh_d       = cnt_sh_q;
        hist_d         = hist_q;
        raw_cnt_d      = raw_cnt_q;
        crc_d          = crc_q;
        crc_l_d        = crc_l_q;
        packet_valid_d = 1'b0;
        crc_error_d    = 1'b0;
        id_d           = id_q;
        error_d        = error_q;
        value_d        = value_q;
        param_count_d  = param_count_q;
        if (frame_err_q) begin
            crc_d = 16'h0000;
        end else if (byte_stb_q) begin
            case (p_state_q)
                P_HDR1: crc_d = (byte_q == 8'hFF) ? crc16_byte(16'h0000, byte_q) : 16'h0000;
                P_HDR2: crc_d = (byte_q == 8'hFF) ? crc_next : 16'h0000;
                P_HDR3: begin
                    // An extra FF slides the header window: the accumulator
                    // already holds CRC(FF FF), which is still correct.
                    if (byte_q == 8'hFD)      crc_d = crc_next;
                    else if (byte_q != 8'hFF) crc_d = 16'h0000;
                end
                P_RSV:  crc_d = (byte_q == 8'h00) ? crc_next : 16'h0000;
                P_ID: begin
                    crc_d     = crc_next;
                    id_sh_d   = byte_q;
                    val_sh_d  = 32'h0;
                    cnt_sh_d  = 8'h00;
                    hist_d    = 24'h0;
                    raw_cnt_d = 2'd0;
                end
                P_LEN_L: begin
                    crc_d = crc_next;
                    len_d = {8'h00, byte_q};
                end
                P_LEN_H: begin
                    len_d = len_full;
                    crc_d = len_bad ? 16'h0000 : crc_next;
                end
                P_INST: crc_d = (byte_q == 8'h55) ? crc_next : 16'h0000;
                P_ERR: begin
                    crc_d    = crc_next;
                    err_sh_d = byte_q;
                    rem_d    = len_q - 16'd4;
                end
                P_PARAM: begin
                    crc_d     = crc_next;
                    rem_d     = rem_q - 16'd1;
                    hist_d    = {hist_q[15:0], byte_q};
                    raw_cnt_d = (raw_cnt_q == 2'd3) ? 2'd3 : raw_cnt_q + 2'd1;
                    if (!is_stuff) begin
                        if (cnt_sh_q < 8'd4) begin
                            val_sh_d[{cnt_sh_q[1:0], 3'b000} +: 8] = byte_q;
                        end
                        cnt_sh_d = (cnt_sh_q == 8'hFF) ? 8'hFF : cnt_sh_q + 8'd1;
                    end
                end
                P_CRC_L: crc_l_d = byte_q;
                P_CRC_H: begin
                    crc_d = 16'h0000;
                    if ({byte_q, crc_l_q} == crc_q) begin
                        packet_valid_d = 1'b1;
                        id_d           = id_sh_q;
                        error_d        = err_sh_q;
                        value_d        = val_sh_q;
                        param_count_d  = cnt_sh_q;
                    end else begin
                        crc_error_d = 1'b1;
                    end
                end
                default: crc_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q      <= 1'b1;
            rx_sync_q      <= 1'b1;
            rx_prev_q      <= 1'b1;
            tmr_q          <= '0;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 8'h00;
            byte_stb_q     <= 1'b0;
            byte_q         <= 8'h00;
            frame_err_q    <= 1'b0;
            len_q          <= 16'h0;
            rem_q          <= 16'h0;
            id_sh_q        <= 8'h00;
            err_sh_q       <= 8'h00;
            val_sh_q       <= 32'h0;
            cnt_sh_q       <= 8'h00;
            hist_q         <= 24'h0;
            raw_cnt_q      <= 2'd0;
            crc_q          <= 16'h0;
            crc_l_q        <= 8'h00;
            packet_valid_q <= 1'b0;
            crc_error_q    <= 1'b0;
            id_q           <= 8'h00;
            error_q        <= 8'h00;
            value_q        <= 32'h0;
            param_count_q  <= 8'h00;
        end else begin
            rx_meta_q      <= rx;
            rx_sync_q      <= rx_meta_q;
            rx_prev_q      <= rx_sync_q;
            tmr_q          <= tmr_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            byte_stb_q     <= byte_stb_d;
            byte_q         <= byte_d;
            frame_err_q    <= frame_err_d;
            len_q          <= len_d;
            rem_q          <= rem_d;
            id_sh_q        <= id_sh_d;
            err_sh_q       <= err_sh_d;
            val_sh_q       <= val_sh_d;
            cnt_sh_q       <= cnt_sh_d;
            hist_q         <= hist_d;
            raw_cnt_q      <= raw_cnt_d;
            crc_q          <= crc_d;
            crc_l_q        <= crc_l_d;
            packet_valid_q <= packet_valid_d;
            crc_error_q    <= crc_error_d;
            id_q           <= id_d;
            error_q        <= error_d;
            value_q        <= value_d;
            param_count_q  <= param_count_d;
        end
    end

    assign packet_valid  = packet_valid_q;
    assign crc_error     = crc_error_q;
    assign framing_error = frame_err_q;
    assign id            = id_q;
    assign error         = error_q;
    assign value         = value_q;
    assign param_count   = param_count_q;

endmodule

// File: tb/tb_dynamixel_status_receiver.sv
// Testbench for dynamixel_status_receiver: packets are encoded by the bench
// (stuffing inserted, CRC by bit-serial polynomial division), expected
// events are queued, and a monitor checks every DUT pulse against the queue.
module tb_dynamixel_status_receiver;

    localparam int CPB = 3;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          kind;   // 0 packet_valid, 1 crc_error, 2 framing_error
        logic [7:0]  id;
        logic [7:0]  err;
        logic [31:0] value;
        logic [7:0]  cnt;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic        packet_valid;
    logic [7:0]  id;
    logic [7:0]  error;
    logic [31:0] value;
    logic [7:0]  param_count;
    logic        crc_error;
    logic        framing_error;

    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    // Model of the published outputs (last valid packet).
    logic [7:0]  m_id = 8'h00;
    logic [7:0]  m_err = 8'h00;
    logic [31:0] m_val = 32'h0;
    logic [7:0]  m_cnt = 8'h00;

    dynamixel_status_receiver #(.clocks_per_bit(CPB), .max_len(64)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rx           (rx),
        .packet_valid (packet_valid),
        .id           (id),
        .error        (error),
        .value        (value),
        .param_count  (param_count),
        .crc_error    (crc_error),
        .framing_error(framing_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] crc_ref(input bq_t m);
        logic [15:0] c;
        logic fb;
        c = 16'h0000;
        foreach (m[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ m[i][b];
                c  = c << 1;
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(CPB);
        end
        rx = stop_ok;
        wait_clk(CPB);
        rx = 1'b1;
        if (!stop_ok) wait_clk(CPB * 3);
    endtask

    task automatic send_bytes(input bq_t p);
        foreach (p[i]) begin
            send_byte(p[i], 1'b1);
            wait_clk($urandom_range(0, CPB));
        end
    endtask

    task automatic push_valid(input logic [7:0] pid, input logic [7:0] perr,
                              input logic [31:0] pval, input logic [7:0] pcnt);
        exp_t e;
        m_id = pid; m_err = perr; m_val = pval; m_cnt = pcnt;
        e.kind = 0; e.id = pid; e.err = perr; e.value = pval; e.cnt = pcnt;
        exp_q.push_back(e);
    endtask

    task automatic push_held(input int kind);
        exp_t e;
        e.kind = kind; e.id = m_id; e.err = m_err; e.value = m_val; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // Encodes destuffed params into a full status packet and queues the
    // expected outcome.
    task automatic build_packet(input logic [7:0] pid, input logic [7:0] perr,
                                input bq_t params, input bit corrupt, output bq_t pkt);
        bq_t raw;
        logic [15:0] len;
        logic [15:0] crc;
        logic [31:0] v;
        int n;
        raw = {};
        foreach (params[i]) begin
            raw.push_back(params[i]);
            n = raw.size();
            if (n >= 3 && raw[n-3] == 8'hFF && raw[n-2] == 8'hFF && raw[n-1] == 8'hFD)
                raw.push_back(8'hFD);
        end
        len = 16'(raw.size() + 4);
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, pid, len[7:0], len[15:8], 8'h55, perr};
        foreach (raw[i]) pkt.push_back(raw[i]);
        crc = crc_ref(pkt);
        if (corrupt) crc = crc ^ (16'h0001 << $urandom_range(0, 15));
        pkt.push_back(crc[7:0]);
        pkt.push_back(crc[15:8]);
        if (corrupt) begin
            push_held(1);
        end else begin
            v = 32'h0;
            for (int k = 0; k < 4 && k < params.size(); k++) v[8*k +: 8] = params[k];
            push_valid(pid, perr, v, (params.size() > 255) ? 8'hFF : 8'(params.size()));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pv"},  {31'h0, packet_valid}, 32'h0);
        check({tag, "_ce"},  {31'h0, crc_error}, 32'h0);
        check({tag, "_fe"},  {31'h0, framing_error}, 32'h0);
        check({tag, "_id"},  {24'h0, id}, 32'h0);
        check({tag, "_err"}, {24'h0, error}, 32'h0);
        check({tag, "_val"}, value, 32'h0);
        check({tag, "_cnt"}, {24'h0, param_count}, 32'h0);
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    initial begin
        exp_t e;
        int kind;
        forever begin
            @(negedge clock);
            if (reset_n && (packet_valid || crc_error || framing_error)) begin
                if (packet_valid && crc_error)
                    check("pv_ce_exclusive", 32'h1, 32'h0);
                kind = packet_valid ? 0 : (crc_error ? 1 : 2);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_kind", kind, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", kind, e.kind);
                    check("id", {24'h0, id}, {24'h0, e.id});
                    check("error", {24'h0, error}, {24'h0, e.err});
                    check("value", value, e.value);
                    check("param_count", {24'h0, param_count}, {24'h0, e.cnt});
                end
            end
        end
    end

    initial begin
        bq_t p;
        bq_t params;
        int waited;
        int np;

        wait_clk(5);
        check_zero_outputs("reset");
        reset_n = 1'b1;
        wait_clk(10);

        // Ping status
        push_valid(8'h01, 8'h00, 32'h0026_0406, 8'd3);
        p = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55, 8'h00,
              8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
        send_bytes(p);
        wait_clk(30);

        // Read status
        push_valid(8'h01, 8'h00, 32'h0000_00A6, 8'd4);
        p = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h08, 8'h00, 8'h55, 8'h00,
              8'hA6, 8'h00, 8'h00, 8'h00, 8'h8C, 8'hC0};
        send_bytes(p);
        wait_clk(30);

        // Bad CRC, then a good ping
        push_held(1);
        p = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55, 8'h00,
              8'h06, 8'h04, 8'h26, 8'h65, 8'h5C};
        send_bytes(p);
        wait_clk(30);
        push_valid(8'h01, 8'h00, 32'h0026_0406, 8'd3);
        p = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55, 8'h00,
              8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
        send_bytes(p);
        wait_clk(30);

        // Stuffed params FF FF FD 10 -> raw FF FF FD FD 10, LEN 9
        params = '{8'hFF, 8'hFF, 8'hFD, 8'h10};
        build_packet(8'h10, 8'h00, params, 1'b0, p);
        check("stuffed_raw_len", p.size(), 32'd16);
        send_bytes(p);
        wait_clk(30);
        check("stuffed_value", value, 32'h10FD_FFFF);

        // Framing error mid-packet, then resync on leading FF
        p = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h02};
        send_bytes(p);
        push_held(2);
        send_byte(8'h55, 1'b0);
        wait_clk(20);
        params = '{8'h11, 8'h22};
        build_packet(8'h03, 8'h40, params, 1'b0, p);
        p.push_front(8'hFF);
        send_bytes(p);
        wait_clk(30);

        // Out-of-range LEN fields are dropped silently
        p = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h05, 8'h03, 8'h00};
        send_bytes(p);
        p = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h05, 8'h41, 8'h00};
        send_bytes(p);
        params = {};
        build_packet(8'h05, 8'h01, params, 1'b0, p);
        send_bytes(p);
        wait_clk(30);

        // Reset mid-packet
        p = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h07};
        send_bytes(p);
        wait_clk(10);
        reset_n = 1'b0;
        wait_clk(3);
        check_zero_outputs("midreset");
        m_id = 8'h00; m_err = 8'h00; m_val = 32'h0; m_cnt = 8'h00;
        reset_n = 1'b1;
        wait_clk(5);
        params = '{8'h5A, 8'hC3, 8'h01};
        build_packet(8'h07, 8'h00, params, 1'b0, p);
        send_bytes(p);
        wait_clk(30);

        // Random packets, biased toward stuffing patterns, some with bad CRC
        for (int t = 0; t < 40; t++) begin
            params = {};
            np = $urandom_range(0, 8);
            for (int k = 0; k < np; k++) begin
                case ($urandom_range(0, 3))
                    0: params.push_back(8'hFF);
                    1: params.push_back(8'hFD);
                    default: params.push_back(8'($urandom));
                endcase
            end
            build_packet(8'($urandom), 8'($urandom), params, ($urandom_range(0, 4) == 0), p);
            send_bytes(p);
            wait_clk($urandom_range(5, 20));
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            wait_clk(1);
            waited++;
        end
        check("pending_expectations", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
